axil_cfg_master: RTL
====================

Name: axil_cfg_master

Overview:
- AXI4-Lite initiator (master) that turns simple command requests into single AXI4-Lite write or read transactions, then returns the response to the requester.
- Drives the AXI4-Lite configuration slave (state/layer control registers) from on-chip logic, e.g. a test sequencer or PS-less bring-up FSM, so no processor is needed.
- One transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32.
- TIMEOUT_CYCLES, 1024, cycles from issue to response before sticky timeout flag sets; 0 disables the timeout.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP copy
- rsp_write  out  1  echo of cmd_write
- timeout  out  1  sticky; cleared only by next command acceptance
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master side, widths per ADDR_WIDTH/DATA_WIDTH

Behaviour:
- Reset (async, aresetn low): state IDLE; all valid/ready outputs 0 except cmd_ready (=1 in IDLE); addr/data/strb/rsp registers 0; timeout 0; awprot=arprot=3'b000 constant.
- All AXI outputs are registered. No combinational path from AXI inputs to AXI outputs.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch addr/wdata/wstrb/write, clear timeout and timer. Next state is WADDR (write) or RADDR (read).
  - WADDR: awvalid and wvalid both assert the cycle after accept. Each drops independently the cycle after its own handshake. When both handshakes are done (same or different cycles), go to WRESP.
  - WRESP: bready=1. On bvalid, capture bresp and set rsp_rdata=0 and rsp_write=1. Go to RSP; bready drops the next cycle.
  - RADDR: arvalid=1 until arready, then go to RDATA.
  - RDATA: rready=1. On rvalid, capture rdata and rresp and set rsp_write=0. Go to RSP.
  - RSP: rsp_valid=1 with stable fields until rsp_ready. Then go to IDLE; cmd_ready=1 the following cycle.
- Valids are never withdrawn before handshake (AXI rule), including after timeout.
- Latency with always-ready slave and rsp_ready=1:
  - Write: accept cycle 0, aw/wvalid cycle 1, bready cycle 2, bvalid cycle 2, rsp_valid cycle 3.
  - Read: accept cycle 0, arvalid cycle 1, rvalid cycle 2, rsp_valid cycle 3.
- Timer counts every cycle in WADDR/WRESP/RADDR/RDATA. When it reaches TIMEOUT_CYCLES, timeout sets and stays set; the transaction is NOT aborted. The timer saturates.
- Response codes are passed unmodified (OKAY 00, SLVERR 10, DECERR 11).
- cmd_* inputs are ignored outside IDLE. The response holds indefinitely while rsp_ready=0.
- Reset mid-transaction: immediate return to IDLE, all valids 0. The bench must reset the slave simultaneously.

Test Plan:
- Write addr 0x0, data 0x0000_0001, wstrb 0xF; slave always ready, bresp 00 → awvalid&wvalid high cycle 1 with awaddr 0x0, wdata 1; rsp_valid cycle 3, rsp_resp 00, rsp_write 1.
- Write with awready delayed 3 cycles, wready immediate → wvalid drops after cycle 1; awvalid held through cycle 4; bready only after both; single rsp.
- Read addr 0x4, slave returns rdata 0x0000_0002, rresp 00 after arready delayed 2 cycles and rvalid 1 further cycle → rsp_rdata 0x2, rsp_write 0; arvalid stable throughout wait.
- Read returning rresp 10 with rsp_ready low 5 cycles → rsp_valid held 5+ cycles, fields stable, cmd_ready 0 until the cycle after rsp_ready.
- TIMEOUT_CYCLES=8, slave never asserts awready for 20 cycles → timeout=1 from 8 cycles after issue, awvalid still 1; completion then yields normal rsp; next command accept clears timeout.
- Assert aresetn low while in WRESP → next edge-independent: bready, awvalid, rsp_valid all 0, cmd_ready 1; a fresh write afterwards completes normally.

Source files
------------

// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: turns single command requests into one AXI4-Lite write or
// read at a time and hands the slave's response back to the requester.
module axil_cfg_master #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_aresetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_write,
   output logic                      timeout,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WADDR,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_RSP
   } state_t;

   state_t                  r_state;
   logic                    r_cmd_ready;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]       r_wstrb;
   logic                    r_awvalid;
   logic                    r_wvalid;
   logic                    r_bready;
   logic                    r_arvalid;
   logic                    r_rready;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]              r_rsp_resp;
   logic                    r_rsp_write;
   logic [TW-1:0]           r_timer;
   logic                    r_timeout;

   logic w_busy;
   logic w_aw_fire;
   logic w_w_fire;

   assign w_busy    = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                      (r_state == S_RADDR) || (r_state == S_RDATA);
   assign w_aw_fire = r_awvalid & m_axi_awready;
   assign w_w_fire  = r_wvalid & m_axi_wready;

   // Transaction sequencer; the timer only flags slow slaves, it never aborts a transfer.
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
         r_rsp_write <= 1'b0;
         r_timer     <= '0;
         r_timeout   <= 1'b0;
      end else begin
         if (w_busy) begin
            if (r_timer != TO_MAX) r_timer <= r_timer + TW'(1);
            if ((TIMEOUT_CYCLES != 0) && (r_timer == TO_LAST)) r_timeout <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  r_wdata     <= cmd_wdata;
                  r_wstrb     <= cmd_wstrb;
                  r_timer     <= '0;
                  r_timeout   <= 1'b0;
                  if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= S_WADDR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_RADDR;
                  end
               end
            end
            S_WADDR: begin
               if (w_aw_fire) r_awvalid <= 1'b0;
               if (w_w_fire)  r_wvalid  <= 1'b0;
               if ((!r_awvalid || w_aw_fire) && (!r_wvalid || w_w_fire)) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (m_axi_bvalid) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= m_axi_bresp;
                  r_rsp_rdata <= '0;
                  r_rsp_write <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RSP;
               end
            end
            S_RADDR: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (m_axi_rvalid) begin
                  r_rready    <= 1'b0;
                  r_rsp_resp  <= m_axi_rresp;
                  r_rsp_rdata <= m_axi_rdata;
                  r_rsp_write <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign rsp_write     = r_rsp_write;
   assign timeout       = r_timeout;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

endmodule
